vga_timing_rx: RTL and testbench

//  Receive end of the VGA link: samples hsync/vsync/RGB (loopback or external probe) on the pixel clock.

---
 rtl/vga_timing_rx_if.sv | 12 +
 rtl/vga_timing_rx.sv | 187 ++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_rx_if.sv
// VGA link bundle: sync pair plus 3-bit-per-channel colour, as driven by a
// generator (master) and sampled by a receiver (slave).
interface vga_timing_rx_if;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [2:0] blue;

  modport master (output hsync, vsync, red, green, blue);
  modport slave  (input  hsync, vsync, red, green, blue);
endinterface

// File: rtl/vga_timing_rx.sv
// VGA receive side: recovers pixel coordinates from the sync pair, measures
// line/frame totals and declares lock against the expected timing.
module vga_timing_rx #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33,
  parameter int unsigned SYNC_ACTIVE_LOW = 1,
  parameter int unsigned LOCK_FRAMES     = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  vga_timing_rx_if.slave    link,
  output logic              pix_valid,
  output logic [9:0]        pix_x,
  output logic [9:0]        pix_y,
  output logic [8:0]        pix_rgb,
  output logic              frame_start,
  output logic              locked,
  output logic [11:0]       h_total,
  output logic [10:0]       v_total,
  output logic [7:0]        err_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned H_END   = H_START + H_ACTIVE;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned V_END   = V_START + V_ACTIVE;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state, next_state;
  logic [3:0]  good_cnt, good_cnt_nxt;

  logic        hs_in, vs_in;
  logic        hs_s, vs_s, hs_d, vs_d;
  logic [8:0]  rgb_s, rgb_d;
  logic [11:0] hcnt;
  logic [10:0] vcnt;
  logic        vs_pend, acc_bad, seen_line;

  logic        hs_lead, vs_lead, boundary;
  logic [12:0] h_len;
  logic [11:0] v_len;
  logic        line_bad_lead, h_sat, line_bad, frame_good;
  logic        lose;
  logic        h_act, v_act, pv_nxt, fs_nxt;
  logic [9:0]  px_nxt, py_nxt;

  // Syncs are normalised to "asserted = 1" before the input register.
  assign hs_in = (SYNC_ACTIVE_LOW != 0) ? ~link.hsync : link.hsync;
  assign vs_in = (SYNC_ACTIVE_LOW != 0) ? ~link.vsync : link.vsync;

  assign hs_lead  = hs_s & ~hs_d;
  assign vs_lead  = vs_s & ~vs_d;
  assign boundary = hs_lead & (vs_pend | vs_lead);

  always_comb begin
    h_len         = {1'b0, hcnt} + 13'd1;
    v_len         = {1'b0, vcnt} + 12'd1;
    line_bad_lead = hs_lead & ((h_len != 13'(H_TOTAL)) | ~seen_line);
    h_sat         = ~hs_lead & (hcnt == '1);
    line_bad      = line_bad_lead | h_sat;
    // The line closed by this hsync still belongs to the frame being judged.
    frame_good    = (v_len == 12'(V_TOTAL)) & ~acc_bad & ~line_bad_lead;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= next_state;
      good_cnt <= good_cnt_nxt;
    end
  end

  always_comb begin
    next_state   = state;
    good_cnt_nxt = good_cnt;
    lose         = 1'b0;
    case (state)
      SEARCH: begin
        good_cnt_nxt = '0;
        if (boundary) next_state = TRACK;
      end
      TRACK: begin
        if (boundary) begin
          if (frame_good) begin
            good_cnt_nxt = good_cnt + 4'd1;
            if (({1'b0, good_cnt} + 5'd1) >= 5'(LOCK_FRAMES)) next_state = LOCKED;
          end else begin
            good_cnt_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (line_bad | (boundary & ~frame_good)) begin
          next_state = SEARCH;
          lose       = 1'b1;
        end
      end
      default: next_state = SEARCH;
    endcase
    if (h_sat) next_state = SEARCH;
  end

  always_comb begin
    h_act  = (hcnt >= 12'(H_START)) && (hcnt < 12'(H_END));
    v_act  = (vcnt >= 11'(V_START)) && (vcnt < 11'(V_END));
    px_nxt = 10'(hcnt - 12'(H_START));
    py_nxt = 10'(vcnt - 11'(V_START));
    pv_nxt = (next_state == LOCKED) & h_act & v_act;
    fs_nxt = pv_nxt & (px_nxt == '0) & (py_nxt == '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hs_s        <= 1'b0;
      vs_s        <= 1'b0;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      rgb_s       <= '0;
      rgb_d       <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      vs_pend     <= 1'b0;
      acc_bad     <= 1'b0;
      seen_line   <= 1'b0;
      h_total     <= '0;
      v_total     <= '0;
      err_count   <= '0;
      locked      <= 1'b0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
    end else begin
      hs_s  <= hs_in;
      vs_s  <= vs_in;
      hs_d  <= hs_s;
      vs_d  <= vs_s;
      rgb_s <= {link.red, link.green, link.blue};
      rgb_d <= rgb_s;

      if (hs_lead) begin
        hcnt      <= '0;
        h_total   <= h_len[11:0];
        seen_line <= 1'b1;
      end else if (hcnt != '1) begin
        hcnt <= hcnt + 12'd1;
      end

      if (boundary) begin
        vcnt    <= '0;
        v_total <= v_len[10:0];
      end else if (hs_lead && (vcnt != '1)) begin
        vcnt <= vcnt + 11'd1;
      end

      vs_pend <= (vs_pend | vs_lead) & ~hs_lead;

      if (boundary)      acc_bad <= 1'b0;
      else if (line_bad) acc_bad <= 1'b1;

      if (lose && (err_count != '1)) err_count <= err_count + 8'd1;

      locked      <= (next_state == LOCKED);
      pix_valid   <= pv_nxt;
      frame_start <= fs_nxt;
      // rgb_d lines up with hcnt/vcnt: both describe the sample taken two edges ago.
      if (pv_nxt) begin
        pix_x   <= px_nxt;
        pix_y   <= py_nxt;
        pix_rgb <= rgb_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx on a reduced 25x13 raster so several
// frames fit in a short run; pixel data carries a coordinate-derived tag.
module tb_vga_timing_rx;
  localparam int HA  = 16;
  localparam int HF  = 2;
  localparam int HS  = 4;
  localparam int HB  = 3;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VA  = 8;
  localparam int VF  = 1;
  localparam int VS  = 2;
  localparam int VB  = 2;
  localparam int VT  = VA + VF + VS + VB;
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [8:0]  pix_rgb;
  logic        frame_start;
  logic        locked;
  logic [11:0] h_total;
  logic [10:0] v_total;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_err = 0;
  int pv_count = 0;
  int fs_count = 0;

  vga_timing_rx_if link();

  vga_timing_rx #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .n_rst(n_rst), .link(link),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked),
    .h_total(h_total), .v_total(v_total), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] tag_rgb(input int x, input int y);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    return {xv[2:0], yv[2:0], xv[3], yv[3], xv[0] ^ yv[0]};
  endfunction

  // Every visible pixel must carry the tag of its own coordinates.
  always @(negedge clk) begin
    if (n_rst && pix_valid) begin
      pv_count++;
      chk("pix_rgb", 32'(pix_rgb), 32'(tag_rgb(int'(pix_x), int'(pix_y))));
    end
    if (n_rst && (frame_start || (pix_valid && pix_x == 10'd0 && pix_y == 10'd0))) begin
      if (frame_start) fs_count++;
      chk("frame_start", 32'({frame_start, pix_valid, pix_x, pix_y}), 32'({2'b11, 20'd0}));
    end
  end

  task automatic drive_pos(input int l, input int p);
    int x, y;
    logic act;
    x = p - HST;
    y = l - VST;
    act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
    @(negedge clk);
    link.hsync = !(p < HS);
    link.vsync = !(l < VS);
    {link.red, link.green, link.blue} = act ? tag_rgb(x, y) : 9'd0;
  endtask

  task automatic send_line(input int l, input int len);
    for (int p = 0; p < len; p++) drive_pos(l, p);
  endtask

  // Counters are cleared after line 0, once the previous frame's last pixels have drained.
  task automatic send_frame(input int nlines);
    send_line(0, HT);
    pv_count = 0;
    fs_count = 0;
    for (int l = 1; l < nlines; l++) send_line(l, HT);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      link.hsync = 1'b1;
      link.vsync = 1'b1;
      {link.red, link.green, link.blue} = 9'd0;
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    chk({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    chk({tag, "_pix_rgb"}, 32'(pix_rgb), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_h_total"}, 32'(h_total), 32'd0);
    chk({tag, "_v_total"}, 32'(v_total), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b0;
    link.hsync = 1'b1;
    link.vsync = 1'b1;
    {link.red, link.green, link.blue} = 9'd0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    n_rst = 1'b1;

    // Nominal stream: lock appears at the third frame boundary.
    send_frame(VT);
    send_frame(VT);
    chk("lock_before_3rd", 32'(locked), 32'd0);
    send_frame(VT);
    chk("lock_after_3rd", 32'(locked), 32'd1);
    chk("h_total_nom", 32'(h_total), 32'(HT));
    chk("v_total_nom", 32'(v_total), 32'(VT));
    chk("pix_per_frame", 32'(pv_count), 32'(HA * VA));
    chk("fs_per_frame", 32'(fs_count), 32'd1);
    chk("hold_valid", 32'(pix_valid), 32'd0);
    chk("hold_x", 32'(pix_x), 32'(HA - 1));
    chk("hold_y", 32'(pix_y), 32'(VA - 1));
    chk("hold_rgb", 32'(pix_rgb), 32'(tag_rgb(HA - 1, VA - 1)));
    chk("err_nom", 32'(err_count), 32'd0);

    // One line stretched by a clock while locked.
    for (int l = 0; l < 6; l++) send_line(l, HT);
    send_line(6, HT + 1);
    drive_pos(7, 0);
    drive_pos(7, 1);
    chk("lock_pre_detect", 32'(locked), 32'd1);
    drive_pos(7, 2);
    chk("lock_drop", 32'(locked), 32'd0);
    chk("err_stretch", 32'(err_count), 32'd1);
    chk("h_total_stretch", 32'(h_total), 32'(HT + 1));
    for (int p = 3; p < HT; p++) drive_pos(7, p);
    for (int l = 8; l < VT; l++) send_line(l, HT);
    send_frame(VT);
    send_frame(VT);
    chk("relock_not_yet", 32'(locked), 32'd0);
    send_frame(VT);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_pix", 32'(pv_count), 32'(HA * VA));

    // Short frame while locked, then again while not locked.
    send_frame(VT - 1);
    send_frame(VT);
    chk("short_lock_lost", 32'(locked), 32'd0);
    chk("short_v_total", 32'(v_total), 32'(VT - 1));
    chk("short_err", 32'(err_count), 32'd2);
    chk("short_no_pix", 32'(pv_count), 32'd0);
    send_frame(VT - 1);
    send_frame(VT);
    chk("short2_err", 32'(err_count), 32'd2);
    chk("short2_lock", 32'(locked), 32'd0);
    chk("short2_v_total", 32'(v_total), 32'(VT - 1));

    // Relock, then lose hsync long enough for the line counter to saturate.
    send_frame(VT);
    send_frame(VT);
    chk("lock_before_idle", 32'(locked), 32'd1);
    pv_count = 0;
    idle(5000);
    chk("sat_lock", 32'(locked), 32'd0);
    chk("sat_err", 32'(err_count), 32'd3);
    chk("sat_no_pix", 32'(pv_count), 32'd0);
    chk("sat_h_total", 32'(h_total), 32'(HT));

    // Relock, then reset in the middle of a frame.
    send_frame(VT);
    send_frame(VT);
    for (int l = 0; l < 6; l++) send_line(l, HT);
    for (int p = 0; p < 10; p++) drive_pos(6, p);
    chk("lock_before_rst", 32'(locked), 32'd1);
    chk("pix_before_rst", 32'(pv_count > 0), 32'd1);
    #1 n_rst = 1'b0;
    #1 chk_cleared("async_rst");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int p = 10; p < HT; p++) drive_pos(6, p);
    for (int l = 7; l < VT; l++) send_line(l, HT);
    send_frame(VT);
    send_frame(VT);
    chk("rst_relock_not_yet", 32'(locked), 32'd0);
    send_frame(VT);
    chk("rst_relock", 32'(locked), 32'd1);
    chk("rst_relock_pix", 32'(pv_count), 32'(HA * VA));
    chk("rst_err", 32'(err_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
